// File: rtl/fft_frame_if.sv
// Stream and core-side bus of the FFT frame controller.
// The controller takes the slave modport; the sample source, downstream sink and FFT core sit on master.
interface fft_frame_if #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [15:0]              in_re;
  logic [15:0]              in_im;
  logic                     in_ifft;
  logic [16*D_WIDTH-1:0]    fft_in_re;
  logic [16*D_WIDTH-1:0]    fft_in_im;
  logic                     fft_start;
  logic                     fft_ifft;
  logic [16*D_WIDTH-1:0]    fft_out_re;
  logic [16*D_WIDTH-1:0]    fft_out_im;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              out_re;
  logic [15:0]              out_im;
  logic [LOG_2_WIDTH-1:0]   out_index;
  logic                     out_last;
  logic                     busy;
  logic                     frame_done;

  modport master (
    output in_valid, in_re, in_im, in_ifft, fft_out_re, fft_out_im, out_ready,
    input  in_ready, fft_in_re, fft_in_im, fft_start, fft_ifft,
           out_valid, out_re, out_im, out_index, out_last, busy, frame_done
  );

  modport slave (
    input  in_valid, in_re, in_im, in_ifft, fft_out_re, fft_out_im, out_ready,
    output in_ready, fft_in_re, fft_in_im, fft_start, fft_ifft,
           out_valid, out_re, out_im, out_index, out_last, busy, frame_done
  );
endinterface

// File: rtl/fft_frame_controller.sv
// Loads one frame into the buffer, starts the FFT core, waits its compute time, streams bins out.
// state  | meaning
// IDLE   | waiting for sample 0, in_ready high
// LOAD   | accepting samples 1..D_WIDTH-1
// START  | one-cycle fft_start, buffer frozen
// RUN    | core computing, FFT_CYCLES cycles
// UNLOAD | presenting bins 0..D_WIDTH-1 on the output stream
module fft_frame_controller #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int FFT_CYCLES  = 192
) (
  input logic        clk,
  input logic        rst,
  fft_frame_if.slave bus
);

  localparam int RUN_W = $clog2(FFT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [LOG_2_WIDTH-1:0] load_cnt;
  logic [LOG_2_WIDTH-1:0] out_idx;
  logic [LOG_2_WIDTH-1:0] out_idx_inc;
  logic [RUN_W-1:0]       run_cnt;
  logic [15:0]            buf_re [D_WIDTH];
  logic [15:0]            buf_im [D_WIDTH];
  logic [15:0]            core_re [D_WIDTH];
  logic [15:0]            core_im [D_WIDTH];
  logic [15:0]            out_re_q;
  logic [15:0]            out_im_q;
  logic                   ifft_q;
  logic                   done_q;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_last;
  logic                   hs_in;
  logic                   hs_out;
  logic                   load_last;
  logic                   run_last;

  for (genvar g = 0; g < D_WIDTH; g++) begin : g_pack
    assign bus.fft_in_re[16*g +: 16] = buf_re[g];
    assign bus.fft_in_im[16*g +: 16] = buf_im[g];
    assign core_re[g] = bus.fft_out_re[16*g +: 16];
    assign core_im[g] = bus.fft_out_im[16*g +: 16];
  end

  assign hs_in       = bus.in_valid & in_ready;
  assign hs_out      = out_valid & bus.out_ready;
  assign load_last   = (load_cnt == LOG_2_WIDTH'(D_WIDTH - 1));
  assign run_last    = (run_cnt == RUN_W'(FFT_CYCLES - 1));
  assign out_idx_inc = out_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs_in) state_nxt = (D_WIDTH == 1) ? START : LOAD;
      LOAD:    if (hs_in && load_last) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (run_last) state_nxt = UNLOAD;
      UNLOAD:  if (hs_out && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    bus.fft_start = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE, LOAD: in_ready = 1'b1;
      START:      bus.fft_start = 1'b1;
      UNLOAD: begin
        out_valid = 1'b1;
        out_last  = (out_idx == LOG_2_WIDTH'(D_WIDTH - 1));
      end
      default: ;
    endcase
  end

  // Output data is a registered mux so it stays put while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
      load_cnt <= '0;
      run_cnt  <= '0;
      out_idx  <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      ifft_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= hs_out & out_last;
      case (state)
        IDLE: if (hs_in) begin
          buf_re[0] <= bus.in_re;
          buf_im[0] <= bus.in_im;
          ifft_q    <= bus.in_ifft;
          load_cnt  <= LOG_2_WIDTH'(1);
        end
        LOAD: if (hs_in) begin
          buf_re[load_cnt] <= bus.in_re;
          buf_im[load_cnt] <= bus.in_im;
          load_cnt         <= load_last ? '0 : load_cnt + 1'b1;
        end
        START: run_cnt <= '0;
        RUN: begin
          if (run_last) begin
            out_idx  <= '0;
            out_re_q <= core_re[0];
            out_im_q <= core_im[0];
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        UNLOAD: if (hs_out) begin
          if (out_last) begin
            out_idx <= '0;
          end else begin
            out_idx  <= out_idx_inc;
            out_re_q <= core_re[out_idx_inc];
            out_im_q <= core_im[out_idx_inc];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_last   = out_last;
  assign bus.out_index  = out_idx;
  assign bus.out_re     = out_re_q;
  assign bus.out_im     = out_im_q;
  assign bus.fft_ifft   = ifft_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_fft_frame_controller.sv
// Directed bench for fft_frame_controller; the bench plays sample source, sink and a static FFT core.
module tb_fft_frame_controller;
  localparam int D  = 64;
  localparam int LW = 6;
  localparam int FC = 192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_if #(.D_WIDTH(D), .LOG_2_WIDTH(LW)) bus ();

  fft_frame_controller #(.D_WIDTH(D), .LOG_2_WIDTH(LW), .FFT_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_re [D];
  logic [15:0] exp_im [D];
  logic        exp_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] core_re_f(input int i);
    return 16'(16'h1000 + i * 37);
  endfunction

  function automatic logic [15:0] core_im_f(input int i);
    return 16'(16'h8000 - i * 5);
  endfunction

  task automatic set_frame(input int pat);
    for (int i = 0; i < D; i++) begin
      if (pat == 0) begin
        exp_re[i] = (i == 0) ? 16'h0100 : 16'h0000;
        exp_im[i] = 16'h0000;
      end else begin
        exp_re[i] = 16'(pat * 4096 + i * 3 + 1);
        exp_im[i] = 16'(~(pat * 256 + i));
      end
    end
  endtask

  task automatic check_buf(input string tag);
    int errs = 0;
    for (int i = 0; i < D; i++)
      if (bus.fft_in_re[16*i +: 16] !== exp_re[i] || bus.fft_in_im[16*i +: 16] !== exp_im[i]) errs++;
    chk(tag, errs, 0);
  endtask

  task automatic check_reset(input string tag);
    chk(tag, {bus.in_ready, bus.fft_start, bus.fft_ifft, bus.out_valid, bus.out_index,
              bus.out_last, bus.busy, bus.frame_done},
             {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0});
    chk({tag, "_buf"}, (|bus.fft_in_re) || (|bus.fft_in_im), 0);
  endtask

  task automatic load_frame(input bit toggle, input bit mode, input bit mode_flip);
    int i = 0, hs = 0, guard = 0, early = 0;
    bit gap = 1'b0;
    bit fire;
    exp_mode = mode;
    while (i < D && guard < 4 * D) begin
      bus.in_valid = !(toggle && gap);
      bus.in_re    = exp_re[i];
      bus.in_im    = exp_im[i];
      bus.in_ifft  = (i == 0) ? mode : (mode_flip ? i[0] : mode);
      fire = bus.in_valid && bus.in_ready;
      if (bus.fft_start) early++;
      tick();
      if (fire) begin
        i++;
        hs++;
      end
      gap = !gap;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_ifft  = mode_flip ? ~mode : mode;
    chk("load_hs", hs, D);
    chk("load_early_start", early, 0);
    chk("start_pulse", bus.fft_start, 1);
    chk("ifft_latch", bus.fft_ifft, mode);
    check_buf("buf_load");
  endtask

  task automatic wait_result(input bit hold);
    int cyc, bad_rdy = 0, bad_mode = 0;
    if (hold) begin
      bus.in_valid = 1'b1;
      bus.in_re    = 16'h7777;
      bus.in_im    = 16'h7777;
    end
    tick();
    chk("start_width", bus.fft_start, 0);
    cyc = 1;
    while (!bus.out_valid && cyc < 400) begin
      if (bus.in_ready || !bus.busy) bad_rdy++;
      if (bus.fft_ifft !== exp_mode) bad_mode++;
      tick();
      cyc++;
    end
    chk("latency", cyc, FC + 1);
    chk("run_in_ready", bad_rdy, 0);
    chk("run_ifft", bad_mode, 0);
  endtask

  task automatic unload(input int stall_idx, input int stall_len, input bit hold);
    int n = 0, idx = 0, stalled = 0, guard = 0, bad = 0;
    bit fire;
    while (n < D && guard < D + stall_len + 50) begin
      bus.out_ready = !(idx == stall_idx && stalled < stall_len);
      if (!bus.out_ready) stalled++;
      chk("out_bin", {bus.out_valid, bus.out_last, bus.out_index, bus.out_re, bus.out_im},
                     {1'b1, idx == D - 1, 6'(idx), core_re_f(idx), core_im_f(idx)});
      if (hold && bus.in_ready) bad++;
      if (bus.frame_done || bus.fft_ifft !== exp_mode) bad++;
      fire = bus.out_valid && bus.out_ready;
      tick();
      if (fire) begin
        n++;
        idx++;
      end
      guard++;
    end
    bus.out_ready = 1'b1;
    chk("unload_hs", n, D);
    chk("unload_lock", bad, 0);
    chk("done_state", {bus.frame_done, bus.out_valid, bus.busy, bus.in_ready, bus.out_index},
                      {1'b1, 1'b0, 1'b0, 1'b1, 6'd0});
    if (hold) check_buf("buf_locked");
    bus.in_valid = 1'b0;
    tick();
    chk("done_pulse", {bus.frame_done, bus.busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_ifft   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.fft_out_re[16*i +: 16] = core_re_f(i);
      bus.fft_out_im[16*i +: 16] = core_im_f(i);
    end
    rst = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // impulse frame, no stalls
    set_frame(0);
    load_frame(1'b0, 1'b0, 1'b0);
    wait_result(1'b0);
    unload(-1, 0, 1'b0);

    // input valid toggling every cycle
    set_frame(1);
    load_frame(1'b1, 1'b0, 1'b0);
    wait_result(1'b0);
    unload(-1, 0, 1'b0);

    // output stall of 10 cycles on bin 5
    set_frame(2);
    load_frame(1'b0, 1'b0, 1'b0);
    wait_result(1'b0);
    unload(5, 10, 1'b0);

    // source keeps in_valid high through RUN and UNLOAD
    set_frame(3);
    load_frame(1'b0, 1'b0, 1'b0);
    wait_result(1'b1);
    unload(-1, 0, 1'b1);

    // ifft mode on sample 0, in_ifft toggling afterwards
    set_frame(4);
    load_frame(1'b0, 1'b1, 1'b1);
    wait_result(1'b0);
    unload(-1, 0, 1'b0);

    // reset at RUN cycle 50, then a fresh frame
    set_frame(5);
    load_frame(1'b0, 1'b0, 1'b0);
    repeat (51) tick();
    chk("abort_in_run", {bus.busy, bus.out_valid, bus.in_ready}, 3'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("abort");
    bad = 0;
    repeat (250) begin
      if (bus.out_valid || bus.busy || bus.fft_start) bad++;
      tick();
    end
    chk("abort_quiet", bad, 0);
    set_frame(6);
    load_frame(1'b0, 1'b0, 1'b0);
    wait_result(1'b0);
    unload(-1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
